// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: holds one instruction, aligns the register
// file's registered read data with it and bypasses same-edge writeback.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  output logic [4:0]      rf_radd1,
  output logic [4:0]      rf_radd2,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            wb_wen,
  input  logic [4:0]      wb_wadd,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_op1,
  output logic [XLEN-1:0] id_op2,
  output logic [31:0]     id_imm,
  output logic [4:0]      id_rd,
  output logic [3:0]      id_alu_op,
  output logic            id_use_imm,
  output logic            id_use_pc,
  output logic            id_reg_wr,
  output logic            id_mem_rd,
  output logic            id_mem_wr,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal
);

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_MISC   = 7'b0001111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  function automatic logic [31:0] i_imm(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] s_imm(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] u_imm(input logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic            full_q, full_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fwd1_v_q, fwd1_v_d, fwd2_v_q, fwd2_v_d;
  logic [XLEN-1:0] fwd1_d_q, fwd1_d_d, fwd2_d_q, fwd2_d_d;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s, rs2_s;
  logic [31:0] imm_s;
  logic [3:0]  alu_op_s;
  logic        reg_wr_s, mem_rd_s, mem_wr_s, branch_s, jump_s, illegal_s;
  logic        use_imm_s, use_pc_s, uses_rs1_s, uses_rs2_s;
  logic        hazard_s, if_ready_s, accept_s;

  assign opcode_s = instr_q[6:0];
  assign funct3_s = instr_q[14:12];
  assign rs1_s    = instr_q[19:15];
  assign rs2_s    = instr_q[24:20];

  // Decode the held instruction into immediate, ALU op and control flags.
  always_comb begin
    imm_s      = 32'h0000_0000;
    alu_op_s   = 4'h0;
    reg_wr_s   = 1'b0;
    mem_rd_s   = 1'b0;
    mem_wr_s   = 1'b0;
    branch_s   = 1'b0;
    jump_s     = 1'b0;
    illegal_s  = 1'b0;
    use_imm_s  = 1'b0;
    use_pc_s   = 1'b0;
    uses_rs1_s = 1'b1;
    uses_rs2_s = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        imm_s = u_imm(instr_q); reg_wr_s = 1'b1; use_imm_s = 1'b1; uses_rs1_s = 1'b0;
      end
      OPC_AUIPC: begin
        imm_s = u_imm(instr_q); reg_wr_s = 1'b1; use_imm_s = 1'b1; use_pc_s = 1'b1;
        uses_rs1_s = 1'b0;
      end
      OPC_JAL: begin
        imm_s = j_imm(instr_q); reg_wr_s = 1'b1; jump_s = 1'b1; use_imm_s = 1'b1;
        use_pc_s = 1'b1; uses_rs1_s = 1'b0;
      end
      OPC_JALR: begin
        imm_s = i_imm(instr_q); reg_wr_s = 1'b1; jump_s = 1'b1; use_imm_s = 1'b1;
      end
      OPC_BRANCH: begin
        imm_s = b_imm(instr_q); branch_s = 1'b1; alu_op_s = {1'b0, funct3_s};
        uses_rs2_s = 1'b1;
      end
      OPC_LOAD: begin
        imm_s = i_imm(instr_q); reg_wr_s = 1'b1; mem_rd_s = 1'b1; use_imm_s = 1'b1;
      end
      OPC_STORE: begin
        imm_s = s_imm(instr_q); mem_wr_s = 1'b1; use_imm_s = 1'b1; uses_rs2_s = 1'b1;
      end
      OPC_OPIMM: begin
        imm_s = i_imm(instr_q); reg_wr_s = 1'b1; use_imm_s = 1'b1;
        // bit 30 is only an opcode bit for shifts-right; elsewhere it is immediate
        if (funct3_s == 3'b101) alu_op_s = {instr_q[30], funct3_s};
        else                    alu_op_s = {1'b0, funct3_s};
      end
      OPC_OP: begin
        reg_wr_s = 1'b1; alu_op_s = {instr_q[30], funct3_s}; uses_rs2_s = 1'b1;
      end
      OPC_MISC: illegal_s = 1'b0;
      default:  illegal_s = 1'b1;
    endcase
  end

  assign hazard_s = full_q & ex_is_load & (ex_rd != 5'd0) &
                    ((uses_rs1_s & (ex_rd == rs1_s)) | (uses_rs2_s & (ex_rd == rs2_s)));
  assign if_ready_s = ~flush & (~full_q | (ex_ready & ~hazard_s));
  assign accept_s   = if_valid & if_ready_s;

  assign if_ready = if_ready_s;
  assign rf_radd1 = accept_s ? if_instr[19:15] : rs1_s;
  assign rf_radd2 = accept_s ? if_instr[24:20] : rs2_s;

  // Next-state for the holding register and the same-edge writeback bypass.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (accept_s) begin
      full_d  = 1'b1;
      instr_d = if_instr;
      pc_d    = if_pc;
    end else if (full_q & ex_ready & ~hazard_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
    fwd1_v_d = wb_wen & (wb_wadd != 5'd0) & (wb_wadd == rf_radd1);
    fwd2_v_d = wb_wen & (wb_wadd != 5'd0) & (wb_wadd == rf_radd2);
    fwd1_d_d = wb_wdata;
    fwd2_d_d = wb_wdata;
  end

  // Stage registers; reset loads a NOP so the decoded bundle reads as zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full_q   <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_q     <= {XLEN{1'b0}};
      fwd1_v_q <= 1'b0;
      fwd2_v_q <= 1'b0;
      fwd1_d_q <= {XLEN{1'b0}};
      fwd2_d_q <= {XLEN{1'b0}};
    end else begin
      full_q   <= full_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      fwd1_v_q <= fwd1_v_d;
      fwd2_v_q <= fwd2_v_d;
      fwd1_d_q <= fwd1_d_d;
      fwd2_d_q <= fwd2_d_d;
    end
  end

  assign id_valid   = full_q & ~hazard_s & ~flush;
  assign id_pc      = pc_q;
  assign id_op1     = (rs1_s == 5'd0) ? {XLEN{1'b0}} : (fwd1_v_q ? fwd1_d_q : rf_rs1);
  assign id_op2     = (rs2_s == 5'd0) ? {XLEN{1'b0}} : (fwd2_v_q ? fwd2_d_q : rf_rs2);
  assign id_imm     = imm_s;
  assign id_alu_op  = alu_op_s;
  // Flags are qualified by full so an empty stage presents an all-zero bundle.
  assign id_reg_wr  = full_q & reg_wr_s & ~illegal_s;
  assign id_rd      = id_reg_wr ? instr_q[11:7] : 5'd0;
  assign id_mem_rd  = full_q & mem_rd_s;
  assign id_mem_wr  = full_q & mem_wr_s;
  assign id_branch  = full_q & branch_s;
  assign id_jump    = full_q & jump_s;
  assign id_illegal = full_q & illegal_s;
  assign id_use_imm = full_q & use_imm_s;
  assign id_use_pc  = full_q & use_pc_s;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, hand-written handshake corner
// cases, and random traffic against a transaction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        nrst;
  logic        if_valid, if_ready, flush;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_radd1, rf_radd2;
  logic [31:0] rf_rs1, rf_rs2;
  logic        wb_wen;
  logic [4:0]  wb_wadd;
  logic [31:0] wb_wdata;
  logic        ex_is_load, ex_ready;
  logic [4:0]  ex_rd;
  logic        id_valid;
  logic [31:0] id_pc, id_op1, id_op2, id_imm;
  logic [4:0]  id_rd;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_use_pc, id_reg_wr, id_mem_rd, id_mem_wr;
  logic        id_branch, id_jump, id_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .nrst(nrst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush),
    .rf_radd1(rf_radd1), .rf_radd2(rf_radd2), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .wb_wen(wb_wen), .wb_wadd(wb_wadd), .wb_wdata(wb_wdata),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_op1(id_op1), .id_op2(id_op2),
    .id_imm(id_imm), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_use_imm(id_use_imm), .id_use_pc(id_use_pc), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_branch(id_branch),
    .id_jump(id_jump), .id_illegal(id_illegal)
  );

  // Register file: registered read, write at the same edge, reads return old data.
  logic [31:0] regs [32] = '{default: 32'd0};
  always @(posedge clk) begin
    rf_rs1 <= regs[rf_radd1];
    rf_rs2 <= regs[rf_radd2];
    if (wb_wen && wb_wadd != 5'd0) regs[wb_wadd] <= wb_wdata;
  end

  wire [7:0] flags_w = {id_reg_wr, id_mem_rd, id_mem_wr, id_branch,
                        id_jump, id_illegal, id_use_imm, id_use_pc};

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_R = 7'b0110011;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_ST};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  flags;  // reg_wr mem_rd mem_wr branch jump illegal use_imm use_pc
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [14];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid = 1'b0; flush = 1'b0; wb_wen = 1'b0; ex_is_load = 1'b0;
    ex_rd = 5'd0; ex_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Reference-model state for the random phase.
  logic [31:0] mregs [32];
  logic        m_held, m_u1, m_u2, k_u1, k_u2, hz, e_ready, e_valid;
  logic [4:0]  m_rs1, m_rs2;
  logic [31:0] m_pc, pc_ctr, prog [3];
  int          fidx, didx, kind;

  initial begin
    nrst = 1'b0; idle(); if_instr = 32'h0000_0013; if_pc = 32'd0;
    wb_wadd = 5'd0; wb_wdata = 32'd0;
    #12;
    chk("reset_hs", {id_valid, if_ready}, 2'b01);
    chk("reset_bundle", {id_pc, id_op1, id_op2, id_imm, id_rd, id_alu_op, flags_w}, 160'd0);
    nrst = 1'b1;
    tick();

    // x5 = 0x1234, then ADD x6,x5,x0
    wb_wen = 1'b1; wb_wadd = 5'd5; wb_wdata = 32'h1234;
    tick();
    wb_wen = 1'b0; if_valid = 1'b1; if_instr = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6);
    if_pc = 32'h100;
    mid(); chk("add_ready", if_ready, 1'b1);
    tick(); if_valid = 1'b0;
    mid();
    chk("add_x6", {id_valid, id_pc, id_op1, id_op2, id_alu_op, id_rd},
        {1'b1, 32'h100, 32'h1234, 32'd0, 4'h0, 5'd6});
    tick();

    // ADDI x7,x5,-1 accepted on the same edge that writes x5 = 0xAA
    if_valid = 1'b1; if_instr = enc_i(12'hFFF, 5'd5, 3'b000, 5'd7, OP_IMM); if_pc = 32'h104;
    wb_wen = 1'b1; wb_wadd = 5'd5; wb_wdata = 32'hAA;
    tick(); idle();
    mid();
    chk("addi_bypass", {id_valid, id_op1, id_imm, id_use_imm, id_rd},
        {1'b1, 32'hAA, 32'hFFFF_FFFF, 1'b1, 5'd7});
    tick();

    // load-use: SW x9,4(x2) held behind LW x9 in EX
    if_valid = 1'b1; if_instr = enc_s(12'd4, 5'd9, 5'd2); if_pc = 32'h108;
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd9; if_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM);
    if_pc = 32'h10C;
    mid(); chk("lu_stall", {id_valid, if_ready}, 2'b00);
    tick();
    wb_wen = 1'b1; wb_wadd = 5'd9; wb_wdata = 32'h55;
    mid(); chk("lu_stall2", {id_valid, if_ready}, 2'b00);
    tick(); idle();
    mid();
    chk("lu_release", {id_valid, id_pc, id_imm, id_op2, id_mem_wr},
        {1'b1, 32'h108, 32'd4, 32'h55, 1'b1});
    tick();

    // backpressure: three instructions, ex_ready low for two cycles
    prog[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd10, OP_IMM);
    prog[1] = enc_i(12'd2, 5'd0, 3'b000, 5'd11, OP_IMM);
    prog[2] = enc_i(12'd3, 5'd0, 3'b000, 5'd12, OP_IMM);
    fidx = 0; didx = 0;
    for (int cyc = 0; cyc < 12 && didx < 3; cyc++) begin
      if_valid = (fidx < 3);
      if_instr = prog[(fidx < 3) ? fidx : 0];
      if_pc    = 32'h200 + 32'(4 * fidx);
      ex_ready = !(cyc == 2 || cyc == 3);
      mid();
      if (id_valid) begin
        chk("bp_order", {id_pc, id_imm}, {32'h200 + 32'(4 * didx), 32'(didx + 1)});
        if (!ex_ready) chk("bp_hold_ready", if_ready, 1'b0);
        else didx++;
      end
      if (if_valid && if_ready) fidx++;
      tick();
    end
    chk("bp_count", {32'(fidx), 32'(didx)}, {32'd3, 32'd3});
    idle();

    // flush with a full stage and an offered instruction
    if_valid = 1'b1; if_instr = enc_i(12'd5, 5'd0, 3'b000, 5'd13, OP_IMM); if_pc = 32'h300;
    ex_ready = 1'b0;
    tick(); if_valid = 1'b0;
    mid(); chk("pre_flush", {id_valid, id_pc}, {1'b1, 32'h300});
    flush = 1'b1; if_valid = 1'b1; if_instr = enc_i(12'd6, 5'd0, 3'b000, 5'd14, OP_IMM);
    if_pc = 32'h304;
    #1; chk("flush_now", {if_ready, id_valid}, 2'b00);
    tick(); idle();
    mid(); chk("flush_after", id_valid, 1'b0);
    tick();

    // decode table
    vecs[0]  = '{enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), 32'hFFFF_FFF8, 4'h0, 8'b0001_0000, 5'd0};
    vecs[1]  = '{enc_u(20'hABCDE, 5'd3, OP_LUI),      32'hABCD_E000, 4'h0, 8'b1000_0010, 5'd3};
    vecs[2]  = '{32'h0000_0073,                        32'h0,         4'h0, 8'b0000_0100, 5'd0};
    vecs[3]  = '{enc_i(12'h403, 5'd1, 3'b101, 5'd4, OP_IMM), 32'h403, 4'hD, 8'b1000_0010, 5'd4};
    vecs[4]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd5), 32'h0,        4'h8, 8'b1000_0000, 5'd5};
    vecs[5]  = '{enc_j(21'h000800, 5'd1),              32'h800,       4'h0, 8'b1000_1011, 5'd1};
    vecs[6]  = '{enc_i(12'h00C, 5'd1, 3'b000, 5'd0, OP_JALR), 32'hC,  4'h0, 8'b1000_1010, 5'd0};
    vecs[7]  = '{enc_s(12'hFFC, 5'd3, 5'd2),           32'hFFFF_FFFC, 4'h0, 8'b0010_0010, 5'd0};
    vecs[8]  = '{enc_i(12'h010, 5'd1, 3'b010, 5'd8, OP_LD), 32'h10,   4'h0, 8'b1100_0010, 5'd8};
    vecs[9]  = '{enc_u(20'h00001, 5'd9, OP_AUIPC),     32'h1000,      4'h0, 8'b1000_0011, 5'd9};
    vecs[10] = '{32'h0FF0_000F,                        32'h0,         4'h0, 8'b0000_0000, 5'd0};
    vecs[11] = '{enc_b(13'h0010, 5'd2, 5'd1, 3'b100), 32'h10,         4'h4, 8'b0001_0000, 5'd0};
    vecs[12] = '{enc_i(12'hFFF, 5'd1, 3'b010, 5'd10, OP_IMM), 32'hFFFF_FFFF, 4'h2, 8'b1000_0010, 5'd10};
    vecs[13] = '{32'h0000_0000,                        32'h0,         4'h0, 8'b0000_0100, 5'd0};
    for (int i = 0; i < 14; i++) begin
      if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = 32'h400 + 32'(4 * i);
      tick(); if_valid = 1'b0;
      mid();
      chk($sformatf("dec%0d", i), {id_valid, id_imm, id_alu_op, flags_w, id_rd},
          {1'b1, vecs[i].imm, vecs[i].alu, vecs[i].flags, vecs[i].rd});
      tick();
    end

    // asynchronous reset while stalled
    if_valid = 1'b1; if_instr = enc_i(12'd7, 5'd0, 3'b000, 5'd15, OP_IMM); if_pc = 32'h500;
    ex_ready = 1'b0;
    tick(); if_valid = 1'b0;
    mid(); chk("pre_rst", id_valid, 1'b1);
    #2 nrst = 1'b0;
    #1 chk("rst_async", {id_valid, if_ready, id_pc, flags_w}, {1'b0, 1'b1, 32'd0, 8'd0});
    nrst = 1'b1;
    tick(); idle();

    // random traffic against the transaction-level model
    for (int r = 0; r < 32; r++) mregs[r] = regs[r];
    m_held = 1'b0; m_u1 = 1'b0; m_u2 = 1'b0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_pc = 32'd0;
    pc_ctr = 32'h1000;
    for (int n = 0; n < 1500; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: if_instr = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)));
        1: if_instr = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
                            5'($urandom_range(0, 7)), OP_IMM);
        2: if_instr = enc_u(20'($urandom), 5'($urandom_range(0, 7)), OP_LUI);
        3: if_instr = enc_s(12'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        4: if_instr = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'b010,
                            5'($urandom_range(0, 7)), OP_LD);
        default: if_instr = enc_b({12'($urandom), 1'b0}, 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7)), 3'b000);
      endcase
      k_u1 = (kind != 2);
      k_u2 = (kind == 0 || kind == 3 || kind == 5);
      if_valid   = ($urandom_range(0, 3) != 0);
      if_pc      = pc_ctr; pc_ctr = pc_ctr + 32'd4;
      flush      = ($urandom_range(0, 9) == 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_rd      = 5'($urandom_range(0, 7));
      wb_wen     = ($urandom_range(0, 1) != 0);
      wb_wadd    = 5'($urandom_range(0, 7));
      wb_wdata   = $urandom;
      mid();
      hz = m_held && ex_is_load && (ex_rd != 5'd0) &&
           ((m_u1 && ex_rd == m_rs1) || (m_u2 && ex_rd == m_rs2));
      e_ready = !flush && (!m_held || (ex_ready && !hz));
      e_valid = m_held && !hz && !flush;
      chk("rnd_hs", {id_valid, if_ready}, {e_valid, e_ready});
      if (e_valid)
        chk("rnd_data", {id_pc, id_op1, id_op2},
            {m_pc, (m_rs1 == 5'd0) ? 32'd0 : mregs[m_rs1], (m_rs2 == 5'd0) ? 32'd0 : mregs[m_rs2]});
      if (flush) m_held = 1'b0;
      else if (if_valid && e_ready) begin
        m_held = 1'b1; m_pc = if_pc; m_rs1 = if_instr[19:15]; m_rs2 = if_instr[24:20];
        m_u1 = k_u1; m_u2 = k_u2;
      end else if (m_held && ex_ready && !hz) m_held = 1'b0;
      if (wb_wen && wb_wadd != 5'd0) mregs[wb_wadd] = wb_wdata;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
